axi_lite_master: RTL and testbench

Single-outstanding AXI4-Lite initiator that turns a simple valid/ready command port into one AXI4-Lite read or write transaction, then returns the result on a held response port. It drives the bridge configuration register slave from on-chip sequencers and the bring-up test harness. It lets the `char_select`, `direct_ctrl` and `debug` registers be programmed and `network_output` be polled without a processor.

---
 rtl/axi_lite_master.sv | 226 ++++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator.
// One valid/ready command in, one held response out.
module axi_lite_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 9,
  parameter int C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;
  localparam int TW =
    (C_TIMEOUT_CYCLES > 1) ? $clog2(C_TIMEOUT_CYCLES) : 1;
  localparam int unsigned TLIM =
    (C_TIMEOUT_CYCLES > 0) ? C_TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] addr_q, addr_nxt;
  logic [DW-1:0] wdata_nxt;
  logic [SW-1:0] wstrb_nxt;
  logic          ready_nxt;
  logic          awvalid_nxt, wvalid_nxt, bready_nxt;
  logic          arvalid_nxt, rready_nxt;
  logic          rvalid_nxt, rto_nxt;
  logic [DW-1:0] rdata_nxt;
  logic [1:0]    resp_nxt;
  logic          wait_st, tmo_hit, fire_tmo;

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr_q;
    wdata_nxt   = M_AXI_WDATA;
    wstrb_nxt   = M_AXI_WSTRB;
    ready_nxt   = cmd_ready;
    awvalid_nxt = M_AXI_AWVALID;
    wvalid_nxt  = M_AXI_WVALID;
    bready_nxt  = M_AXI_BREADY;
    arvalid_nxt = M_AXI_ARVALID;
    rready_nxt  = M_AXI_RREADY;
    rvalid_nxt  = rsp_valid;
    rdata_nxt   = rsp_rdata;
    resp_nxt    = rsp_resp;
    rto_nxt     = rsp_timeout;
    fire_tmo    = 1'b0;
    wait_st     = (state == WR_ADDR_DATA) ||
                  (state == WR_RESP) ||
                  (state == RD_ADDR) ||
                  (state == RD_DATA);
    tmo_hit     = (C_TIMEOUT_CYCLES != 0) &&
                  (cnt == TW'(TLIM));

    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          ready_nxt = 1'b0;
          addr_nxt  = cmd_addr;
          wdata_nxt = cmd_wdata;
          wstrb_nxt = cmd_wstrb;
          if (cmd_write) begin
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            state_nxt   = WR_ADDR_DATA;
          end else begin
            arvalid_nxt = 1'b1;
            state_nxt   = RD_ADDR;
          end
        end
      end
      WR_ADDR_DATA: begin
        if (M_AXI_AWREADY) awvalid_nxt = 1'b0;
        if (M_AXI_WREADY)  wvalid_nxt  = 1'b0;
        if ((!M_AXI_AWVALID || M_AXI_AWREADY) &&
            (!M_AXI_WVALID  || M_AXI_WREADY)) begin
          bready_nxt = 1'b1;
          state_nxt  = WR_RESP;
        end else if (tmo_hit) begin
          fire_tmo = 1'b1;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_nxt = 1'b0;
          rvalid_nxt = 1'b1;
          rdata_nxt  = '0;
          resp_nxt   = M_AXI_BRESP;
          state_nxt  = RESP;
        end else if (tmo_hit) begin
          fire_tmo = 1'b1;
        end
      end
      RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RD_DATA;
        end else if (tmo_hit) begin
          fire_tmo = 1'b1;
        end
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          rready_nxt = 1'b0;
          rvalid_nxt = 1'b1;
          rdata_nxt  = M_AXI_RDATA;
          resp_nxt   = M_AXI_RRESP;
          state_nxt  = RESP;
        end else if (tmo_hit) begin
          fire_tmo = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rvalid_nxt = 1'b0;
          rto_nxt    = 1'b0;
          ready_nxt  = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // hung slave: abandon the channel and report SLVERR
    if (fire_tmo) begin
      awvalid_nxt = 1'b0;
      wvalid_nxt  = 1'b0;
      bready_nxt  = 1'b0;
      arvalid_nxt = 1'b0;
      rready_nxt  = 1'b0;
      rvalid_nxt  = 1'b1;
      rdata_nxt   = '0;
      resp_nxt    = 2'b10;
      rto_nxt     = 1'b1;
      state_nxt   = RESP;
    end

    if (wait_st && (state_nxt == state))
      cnt_nxt = cnt + TW'(1);
    else
      cnt_nxt = '0;
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state         <= IDLE;
      cnt           <= '0;
      addr_q        <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      cmd_ready     <= 1'b1;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      rsp_timeout   <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      addr_q        <= addr_nxt;
      M_AXI_WDATA   <= wdata_nxt;
      M_AXI_WSTRB   <= wstrb_nxt;
      cmd_ready     <= ready_nxt;
      M_AXI_AWVALID <= awvalid_nxt;
      M_AXI_WVALID  <= wvalid_nxt;
      M_AXI_BREADY  <= bready_nxt;
      M_AXI_ARVALID <= arvalid_nxt;
      M_AXI_RREADY  <= rready_nxt;
      rsp_valid     <= rvalid_nxt;
      rsp_rdata     <= rdata_nxt;
      rsp_resp      <= resp_nxt;
      rsp_timeout   <= rto_nxt;
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: directed + random transactions against a
// behavioural AXI4-Lite slave and a word-array reference model.
module tb_axi_lite_master;

  localparam int TO = 8;
  localparam logic [101:0] RST_OUTS = {1'b1, 101'd0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [8:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [8:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready;
  logic        rvalid, rready;

  int n_chk = 0;
  int n_fail = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  s_resp = 2'b00;
  logic [31:0] ref_mem [128];

  always #5 clk = ~clk;

  axi_lite_master #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ADDR_WIDTH(9),
    .C_TIMEOUT_CYCLES(TO)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0]  s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // behavioural slave
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  int          n_aw, n_w;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [8:0]  s_awaddr, pend_addr, r_addr;
  logic [31:0] s_wdata, pend_data;
  logic [3:0]  s_wstrb, pend_strb;
  logic [31:0] smem [128];
  bit          swr [128];
  logic        aw_now, w_now;

  function automatic logic [31:0] s_word(input logic [8:0] a);
    return swr[a[8:2]] ? smem[a[8:2]] : init_val(int'(a[8:2]));
  endfunction

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid && (w_cnt >= w_dly);
  assign arready = arvalid && (ar_cnt >= ar_dly);
  assign bvalid  = b_pend && (b_cnt >= b_dly);
  assign bresp   = bvalid ? s_resp : 2'b00;
  assign rvalid  = r_pend && (r_cnt >= r_dly);
  assign rresp   = rvalid ? s_resp : 2'b00;
  assign rdata   = rvalid ? s_word(r_addr) : 32'd0;
  assign aw_now  = aw_got || (awvalid && awready);
  assign w_now   = w_got || (wvalid && wready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      b_cnt <= 0; r_cnt <= 0; n_aw <= 0; n_w <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      b_pend <= 1'b0; r_pend <= 1'b0;
      s_awaddr <= '0; pend_addr <= '0; r_addr <= '0;
      s_wdata <= '0; pend_data <= '0;
      s_wstrb <= '0; pend_strb <= '0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (awvalid && awready) begin
        aw_got <= 1'b1; s_awaddr <= awaddr; n_aw <= n_aw + 1;
      end
      if (wvalid && wready) begin
        w_got <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb;
        n_w <= n_w + 1;
      end
      if (aw_now && w_now && !b_pend) begin
        b_pend <= 1'b1; b_cnt <= 0;
        aw_got <= 1'b0; w_got <= 1'b0;
        pend_addr <= aw_got ? s_awaddr : awaddr;
        pend_data <= w_got ? s_wdata : wdata;
        pend_strb <= w_got ? s_wstrb : wstrb;
      end
      if (b_pend) begin
        if (bvalid && bready) begin
          b_pend <= 1'b0;
          smem[pend_addr[8:2]] <=
            merge(s_word(pend_addr), pend_data, pend_strb);
          swr[pend_addr[8:2]] <= 1'b1;
        end else begin
          b_cnt <= b_cnt + 1;
        end
      end
      if (arvalid && arready) begin
        r_pend <= 1'b1; r_addr <= araddr; r_cnt <= 0;
      end
      if (r_pend) begin
        if (rvalid && rready) r_pend <= 1'b0;
        else r_cnt <= r_cnt + 1;
      end
    end
  end

  function automatic logic [101:0] outs();
    return {cmd_ready, awaddr, awvalid, wdata, wstrb, wvalid,
            bready, araddr, arvalid, rready, rsp_valid,
            rsp_rdata, rsp_resp, rsp_timeout, awprot, arprot};
  endfunction

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command; expectations come from the slave delay settings.
  task automatic issue(input bit wr, input logic [8:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input bit hold);
    int k, lat, bad, naw0, nw0, idx;
    int e_aw, e_w, e_b, e_ar, e_r;
    int c_aw, c_w, c_b, c_ar, c_r;
    bit seen, to;
    logic [31:0] e_data;
    logic [1:0]  e_resp;
    idx = int'(a[8:2]);
    e_aw = 0; e_w = 0; e_b = 0; e_ar = 0; e_r = 0;
    e_data = 32'd0; e_resp = s_resp; to = 1'b0;
    if (wr) begin
      lat  = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
      e_aw = 1 + aw_dly; e_w = 1 + w_dly; e_b = 1 + b_dly;
    end else if (ar_dly >= TO) begin
      lat = TO + 1; e_ar = TO; to = 1'b1; e_resp = 2'b10;
    end else begin
      lat  = 3 + ar_dly + r_dly;
      e_ar = 1 + ar_dly; e_r = 1 + r_dly;
      e_data = ref_mem[idx];
    end
    naw0 = n_aw; nw0 = n_w;
    chk("idle_ready", 128'(cmd_ready), 128'(1));
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a;
    cmd_wdata = d; cmd_wstrb = s;
    @(posedge clk);
    k = 0; seen = 1'b0; bad = 0;
    c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        cmd_valid = 1'b0;
        chk("accepted", 128'(cmd_ready), 128'(0));
      end
      if (awvalid) c_aw++;
      if (wvalid) c_w++;
      if (bready) c_b++;
      if (arvalid) c_ar++;
      if (rready) c_r++;
      if (awvalid && awaddr !== a) bad++;
      if (wvalid && (wdata !== d || wstrb !== s)) bad++;
      if (arvalid && araddr !== a) bad++;
      if (rsp_valid) seen = 1'b1;
    end
    chk("rsp_seen", 128'(seen), 128'(1));
    chk("latency", 128'(k), 128'(lat));
    chk("awvalid_cycles", 128'(c_aw), 128'(e_aw));
    chk("wvalid_cycles", 128'(c_w), 128'(e_w));
    chk("bready_cycles", 128'(c_b), 128'(e_b));
    chk("arvalid_cycles", 128'(c_ar), 128'(e_ar));
    chk("rready_cycles", 128'(c_r), 128'(e_r));
    chk("chan_stable", 128'(bad), 128'(0));
    chk("aw_handshakes", 128'(n_aw - naw0), 128'(wr ? 1 : 0));
    chk("w_handshakes", 128'(n_w - nw0), 128'(wr ? 1 : 0));
    chk("rsp_rdata", 128'(rsp_rdata), 128'(e_data));
    chk("rsp_resp", 128'(rsp_resp), 128'(e_resp));
    chk("rsp_timeout", 128'(rsp_timeout), 128'(to));
    if (wr) ref_mem[idx] = merge(ref_mem[idx], d, s);
    if (!hold) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("released", 128'({cmd_ready, rsp_valid, rsp_timeout}),
          128'(3'b100));
    end
  endtask

  initial begin
    int k, bad;
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
    #1 rst_n = 1'b0;
    #1 chk("reset_outputs", 128'(outs()), 128'(RST_OUTS));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b1, 9'h008, 32'h0000_A5A5, 4'hF, 1'b0);
    issue(1'b1, 9'h004, 32'h0000_0003, 4'hF, 1'b0);
    r_dly = 5;
    issue(1'b0, 9'h004, 32'd0, 4'h0, 1'b0);
    r_dly = 0;
    w_dly = 3;
    issue(1'b1, 9'h010, 32'h1234_5678, 4'h5, 1'b0);
    w_dly = 0;
    ar_dly = 1000;
    issue(1'b0, 9'h020, 32'd0, 4'h0, 1'b0);
    ar_dly = 0;

    s_resp = 2'b01;
    issue(1'b1, 9'h014, 32'hDEAD_BEEF, 4'hF, 1'b1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 9'h008;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0) bad++;
      if ({rsp_valid, rsp_rdata, rsp_resp, rsp_timeout} !==
          {1'b1, 32'd0, 2'b01, 1'b0}) bad++;
    end
    chk("backpressure_hold", 128'(bad), 128'(0));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_release", 128'({cmd_ready, rsp_valid}), 128'(2'b10));
    s_resp = 2'b00;
    issue(1'b0, 9'h008, 32'd0, 4'h0, 1'b0);

    b_dly = 6;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h00C;
    cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while (!bready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("reach_wr_resp", 128'(bready), 128'(1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("mid_txn_reset", 128'(outs()), 128'(RST_OUTS));
    @(negedge clk);
    rst_n = 1'b1;
    b_dly = 0;
    @(negedge clk);
    issue(1'b0, 9'h00C, 32'd0, 4'h0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      aw_dly = $urandom_range(0, 4);
      w_dly  = $urandom_range(0, 4);
      b_dly  = $urandom_range(0, 4);
      ar_dly = $urandom_range(0, 4);
      r_dly  = $urandom_range(0, 4);
      s_resp = 2'($urandom_range(0, 3));
      issue($urandom_range(0, 1) == 1,
            9'($urandom_range(0, 127) * 4),
            $urandom, 4'($urandom_range(0, 15)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
